// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency display controller.
package freq_pkg;

  localparam int unsigned BCD_DIGITS  = 9;
  localparam int unsigned DISP_DIGITS = 6;
  localparam int unsigned KHZ_DIGIT   = 3;
  localparam int unsigned BCD_W       = BCD_DIGITS * 4;
  localparam int unsigned DISP_W      = DISP_DIGITS * 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RANGE
  } state_t;

  // Window offset k: lowest displayed digit, so that the most significant
  // nonzero digit lands in the leftmost display position (k = 0..3).
  function automatic logic [1:0] window_sel(input logic [BCD_W-1:0] bcd);
    logic [3:0] msd;
    msd = '0;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = 4'(i);
    end
    if (msd <= 4'd5) return '0;
    else             return 2'(msd - 4'd5);
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, IN_W cycles total.
module bin2bcd_seq
  import freq_pkg::*;
#(
  parameter int unsigned IN_W = 27
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [IN_W-1:0]  bin_in,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd_out
);

  localparam int unsigned CNT_W = $clog2(IN_W + 1);

  logic [IN_W-1:0]  bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] bit_cnt;

  // Add-3 correction on every digit that is 5 or more before the shift.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
  end

  // Load on start, then shift {bcd, bin} left once per cycle until the count runs out.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      bin_sr  <= '0;
      bcd_sr  <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
    end else if (start && !busy) begin
      bin_sr  <= bin_in;
      bcd_sr  <= '0;
      bit_cnt <= CNT_W'(IN_W);
      busy    <= 1'b1;
    end else if (busy) begin
      bcd_sr  <= {bcd_adj[BCD_W-2:0], bin_sr[IN_W-1]};
      bin_sr  <= {bin_sr[IN_W-2:0], 1'b0};
      bit_cnt <= bit_cnt - 1'b1;
      if (bit_cnt == CNT_W'(1)) busy <= 1'b0;
    end
  end

  // done marks the cycle whose edge performs the final shift, so the caller
  // can step to its next state in lockstep with the result becoming valid.
  assign done    = busy && (bit_cnt == CNT_W'(1));
  assign bcd_out = bcd_sr;

endmodule

// File: rtl/freq_disp_ctrl.sv
// Frequency display controller: binary sample -> BCD -> auto-ranged 6-digit window.
module freq_disp_ctrl
  import freq_pkg::*;
#(
  parameter int unsigned IN_W = 27
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [IN_W-1:0]   freq_bin,
  input  logic              freq_valid,
  output logic              ready,
  output logic [DISP_W-1:0] data_out,
  output logic [5:0]        dot_out,
  output logic              range_khz,
  output logic              done
);

  state_t            state, state_nxt;
  logic              conv_start;
  logic              conv_busy;
  logic              conv_done;
  logic [BCD_W-1:0]  bcd;
  logic [1:0]        win_k;
  logic [DISP_W-1:0] disp_nxt;
  logic [5:0]        dot_nxt;

  bin2bcd_seq #(
    .IN_W (IN_W)
  ) u_bin2bcd (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (conv_start),
    .bin_in  (freq_bin),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd_out (bcd)
  );

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic and converter start strobe.
  always_comb begin
    state_nxt  = state;
    conv_start = 1'b0;
    case (state)
      IDLE: begin
        if (freq_valid && !conv_busy) begin
          conv_start = 1'b1;
          state_nxt  = SHIFT;
        end
      end
      SHIFT:   if (conv_done) state_nxt = RANGE;
      RANGE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = (state == IDLE);

  // Window selection: six digits starting at k; dot marks the thousands boundary.
  always_comb begin
    win_k    = window_sel(bcd);
    disp_nxt = bcd[DISP_W-1:0];
    dot_nxt  = '0;
    case (win_k)
      2'd0: disp_nxt = bcd[23:0];
      2'd1: disp_nxt = bcd[27:4];
      2'd2: disp_nxt = bcd[31:8];
      2'd3: disp_nxt = bcd[35:12];
      default: disp_nxt = bcd[23:0];
    endcase
    if (win_k != 2'd0) dot_nxt = 6'b000001 << (2'(KHZ_DIGIT) - win_k);
  end

  // Output registers: update once per conversion, hold otherwise.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      data_out  <= '0;
      dot_out   <= '0;
      range_khz <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == RANGE) begin
        data_out  <= disp_nxt;
        dot_out   <= dot_nxt;
        range_khz <= (win_k != 2'd0);
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_freq_disp_ctrl.sv
// Self-checking bench for freq_disp_ctrl against a decimal-arithmetic reference model.
module tb_freq_disp_ctrl;

  localparam int unsigned IN_W = 27;

  logic            sys_clk;
  logic            sys_rst;
  logic [IN_W-1:0] freq_bin;
  logic            freq_valid;
  logic            ready;
  logic [23:0]     data_out;
  logic [5:0]      dot_out;
  logic            range_khz;
  logic            done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned done_cnt = 0;

  freq_disp_ctrl #(
    .IN_W (IN_W)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .freq_bin   (freq_bin),
    .freq_valid (freq_valid),
    .ready      (ready),
    .data_out   (data_out),
    .dot_out    (dot_out),
    .range_khz  (range_khz),
    .done       (done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Count done pulses, sampled just after each active edge.
  always @(posedge sys_clk) begin
    #1;
    if (done) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by division, window chosen from the leading digit.
  task automatic model(input longint unsigned v, output logic [23:0] d,
                       output logic [5:0] dot, output logic khz);
    int unsigned dig[9];
    int unsigned msd;
    int unsigned k;
    longint unsigned t;
    t   = v;
    msd = 0;
    for (int unsigned i = 0; i < 9; i++) begin
      dig[i] = int'(t % 10);
      t      = t / 10;
      if (dig[i] != 0) msd = i;
    end
    k = (msd <= 5) ? 0 : msd - 5;
    d = '0;
    for (int unsigned j = 0; j < 6; j++) d[4*j +: 4] = 4'(dig[k+j]);
    dot = (k == 0) ? 6'd0 : 6'(1 << (3 - k));
    khz = (k != 0);
  endtask

  task automatic check_result(input string tag, input longint unsigned v);
    logic [23:0] ed;
    logic [5:0]  edot;
    logic        ekhz;
    model(v, ed, edot, ekhz);
    check({tag, "_data"}, 32'(data_out), 32'(ed));
    check({tag, "_dot"}, 32'(dot_out), 32'(edot));
    check({tag, "_khz"}, 32'(range_khz), 32'(ekhz));
    check({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  // Present one sample for one cycle and check result, latency and single done pulse.
  task automatic run_sample(input string tag, input logic [IN_W-1:0] v);
    int unsigned cyc;
    int unsigned d0;
    @(negedge sys_clk);
    check({tag, "_rdy_before"}, 32'(ready), 32'd1);
    freq_bin   = v;
    freq_valid = 1'b1;
    d0 = done_cnt;
    @(negedge sys_clk);
    freq_valid = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge sys_clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(IN_W + 1));
    check_result(tag, longint'(v));
    @(negedge sys_clk);
    check({tag, "_one_pulse"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    logic [IN_W-1:0] rv;
    int unsigned d0;
    int unsigned cyc;

    sys_rst    = 1'b0;
    freq_valid = 1'b1;
    freq_bin   = IN_W'(555555);
    repeat (4) @(negedge sys_clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_dot", 32'(dot_out), 32'h0);
    check("rst_khz", 32'(range_khz), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    freq_valid = 1'b0;
    sys_rst    = 1'b1;
    @(negedge sys_clk);
    check("rst_no_accept", 32'(ready), 32'd1);

    run_sample("s123456", IN_W'(123456));
    check("s123456_lit", 32'(data_out), 32'h123456);
    run_sample("s999999", IN_W'(999999));
    run_sample("s1000000", IN_W'(1000000));
    check("s1000000_dot_lit", 32'(dot_out), 32'b000100);
    run_sample("s1234567", IN_W'(1234567));
    run_sample("smax", IN_W'(134217727));
    check("smax_lit", 32'(data_out), 32'h134217);
    run_sample("s0", IN_W'(0));
    run_sample("s9999999", IN_W'(9999999));
    run_sample("s99999999", IN_W'(99999999));
    run_sample("s100000000", IN_W'(100000000));

    // Sample presented mid-conversion must be ignored.
    @(negedge sys_clk);
    freq_bin   = IN_W'(123456);
    freq_valid = 1'b1;
    d0 = done_cnt;
    @(negedge sys_clk);
    freq_valid = 1'b0;
    repeat (9) @(negedge sys_clk);
    check("busy_ready", 32'(ready), 32'd0);
    freq_bin   = IN_W'(777777);
    freq_valid = 1'b1;
    @(negedge sys_clk);
    freq_valid = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge sys_clk);
      cyc++;
    end
    check_result("busy", 123456);
    repeat (40) @(negedge sys_clk);
    check("busy_pulses", 32'(done_cnt - d0), 32'd1);
    check("busy_hold", 32'(data_out), 32'h123456);

    // Reset in the middle of a conversion.
    @(negedge sys_clk);
    freq_bin   = IN_W'(654321);
    freq_valid = 1'b1;
    @(negedge sys_clk);
    freq_valid = 1'b0;
    repeat (14) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_data", 32'(data_out), 32'h0);
    check("midrst_dot", 32'(dot_out), 32'h0);
    check("midrst_khz", 32'(range_khz), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    sys_rst = 1'b1;
    d0 = done_cnt;
    repeat (35) @(negedge sys_clk);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    run_sample("s42", IN_W'(42));
    check("s42_lit", 32'(data_out), 32'h000042);

    // Random samples spread across magnitudes.
    for (int i = 0; i < 24; i++) begin
      rv = IN_W'($urandom) >> $urandom_range(0, IN_W - 1);
      run_sample("rand", rv);
    end

    // freq_valid held high: back-to-back accepts at IN_W+2 cycle spacing.
    @(negedge sys_clk);
    freq_bin   = IN_W'(2500000);
    freq_valid = 1'b1;
    d0 = done_cnt;
    repeat (3 * (IN_W + 2)) @(negedge sys_clk);
    check("hold_pulses", 32'(done_cnt - d0), 32'd3);
    freq_valid = 1'b0;
    repeat (IN_W + 3) @(negedge sys_clk);
    check_result("hold", 2500000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_disp_ctrl.md
Name: freq_disp_ctrl

Overview:
Sits between the frequency-measurement core and the six-digit multiplexed seven-segment display driver. It accepts a binary frequency sample and converts it to BCD with a sequential double-dabble engine. It then auto-ranges the result into a 6-digit window and drives the driver's 24-bit BCD data bus and 6-bit decimal-point select. It owns the display content and the Hz/kHz range indication.

Parameters:
IN_W, 27, width of binary frequency input; legal range 17..29; BCD result is always 9 digits.

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous active-low reset
freq_bin  in  IN_W  binary frequency sample, Hz
freq_valid  in  1  sample strobe; accepted only when ready=1
ready  out  1  high when idle and able to accept a sample
data_out  out  24  six BCD nibbles to the display driver; nibble i = data_out[4i+3:4i], nibble 0 is rightmost
dot_out  out  6  decimal-point select; bit i lights DP of nibble i
range_khz  out  1  1 = window is in kHz units, 0 = Hz
done  out  1  one-cycle pulse when data_out, dot_out and range_khz update

Behaviour:
- Reset (sys_rst=0 at a sys_clk edge): state IDLE; ready=1; data_out=0; dot_out=0; range_khz=0; done=0; internal shift registers cleared. Reset has priority over everything, including mid-conversion; any sample in flight is discarded.
- FSM states:
  - IDLE: ready=1. When freq_valid=1, the edge latches freq_bin into the binary shift register, clears the 36-bit BCD register, loads bit counter = IN_W, and moves to SHIFT.
  - SHIFT: ready=0. Each cycle, add 3 to every BCD digit that is ≥5, then shift {bcd, bin} left by 1 and decrement the counter. After IN_W shifts, move to RANGE.
  - RANGE: ready=0. Compute msd = index of the highest nonzero BCD digit, with msd=0 for value 0. Compute window k = (msd ≤ 5) ? 0 : msd−5, so k ∈ 0..3. Register the outputs, pulse done, and return to IDLE.
- Output mapping in RANGE:
  - data_out = BCD digits k+5..k, with digit k+5 in nibble 5.
  - k=0: dot_out=000000, range_khz=0.
  - k≥1: dot_out has only bit (3−k) set (the thousands boundary), range_khz=1. So k=1 → 000100, k=2 → 000010, k=3 → 000001.
  - Digits below the window are truncated, never rounded. Leading zeros are displayed; there is no blanking.
- Latency: if the sample is accepted at edge E0, outputs, done=1 and ready=1 are all visible after edge E0+IN_W+1. Throughput is one sample per IN_W+2 cycles.
- freq_valid while ready=0 is ignored, with no queueing and no error flag. freq_valid held high in IDLE re-accepts on the cycle after ready rises.
- Outputs hold their last value between updates; the display driver may sample them at any time.
- Arithmetic: per-digit add-3 is 4-bit and never overflows, because the value is ≤9 before correction. Input ≤ 2^29−1 always fits in 9 BCD digits.

Decomposition:
- Shared package (freq_pkg) holds:
  - the FSM state encoding (IDLE, SHIFT, RANGE);
  - BCD_DIGITS=9 and DISP_DIGITS=6;
  - the KHZ_DIGIT=3 constant for dot placement.
- One sub-module, bin2bcd_seq, contains the SHIFT engine: start/busy/done handshake and the IN_W-cycle double-dabble. freq_disp_ctrl keeps the accept logic, range selection and output registers.

Test Plan:
1. Reset → data_out=0x000000, dot_out=000000, range_khz=0, ready=1, done=0. Also hold freq_valid=1 during reset → nothing is accepted.
2. freq_bin=123456 → after 29 cycles (IN_W=27): data_out=0x123456, dot_out=000000, range_khz=0, one done pulse, ready=1.
3. freq_bin=999999 → 0x999999, dot 000000, Hz. Then freq_bin=1000000 → 0x100000, dot 000100, kHz ("1000.00"). Then freq_bin=1234567 → 0x123456, dot 000100.
4. freq_bin=134217727 → k=3: data_out=0x134217, dot_out=000001, range_khz=1. freq_bin=0 → 0x000000, dot 000000, Hz.
5. Accept 123456, then pulse freq_valid with 777777 at cycle 10 of SHIFT → result is 0x123456 only, a single done pulse, and 777777 is never displayed.
6. Assert sys_rst at cycle 15 of SHIFT → next edge gives all outputs at reset values and ready=1. A new sample 42 then converts cleanly to 0x000042.
